// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes,
// receiver state encoding and the parity-check helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4,
      BRK_WAIT = 3'd5
   } rx_state_e;

   // ones_odd is the XOR-reduction of the data word, par the received parity bit
   function automatic logic parity_err(input logic ones_odd, input logic par, input int mode);
      logic err;
      case (mode)
         PAR_ODD:  err = ~(ones_odd ^ par);
         PAR_EVEN: err = ones_odd ^ par;
         default:  err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Valid/ready word delivery from the UART receiver to its consumer,
// carrying the received word and its status flags.
interface uart_rx_os_if #(parameter int DATA_BITS = 8);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 fe;
   logic                 pe;
   logic                 oe;
   logic                 be;

   modport master (output rx_data, rx_valid, fe, pe, oe, be, input rx_ready);
   modport slave  (input rx_data, rx_valid, fe, pe, oe, be, output rx_ready);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; both stages
// reset to 1 so the line reads idle straight out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // Two-stage metastability filter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         q_r    <= 1'b1;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable data width, parity and stop
// bits. Break detection is built only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1,
   parameter int OSR         = 16
) (
   input  logic          UART_clk,
   input  logic          rst_n,
   input  logic          baud_tick,
   input  logic          rx,
   output logic          busy,
   uart_rx_os_if.master  bus
);

   localparam int CNT_W = $clog2(OSR);
   localparam int HALF  = OSR / 2;

   logic                 rxs_s;
   rx_state_e            state_r;
   rx_state_e            state_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [3:0]           bit_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] data_r;
   logic                 par_r;
   logic                 stop_err_r;
   logic                 valid_r;
   logic                 fe_r;
   logic                 pe_r;
   logic                 oe_r;
   logic                 be_r;
   logic                 busy_r;
   logic                 samp_s;
   logic                 last_data_s;
   logic                 done_s;
   logic                 fe_s;
   logic                 pe_s;
   logic                 brk_s;
   logic                 load_s;
`ifdef UART_RX_BREAK_DET_EN
   logic                 stop1_zero_r;
   logic                 first_stop_zero_s;
`endif

   uart_sync2 u_sync (
      .clk   (UART_clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rxs_s)
   );

   // State register
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!rxs_s) state_s = START;
            else        state_s = IDLE;
         end
         START: begin
            if (samp_s) state_s = rxs_s ? IDLE : DATA;
            else        state_s = START;
         end
         DATA: begin
            if (samp_s && last_data_s) state_s = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
            else                       state_s = DATA;
         end
         PARITY: begin
            if (samp_s) state_s = STOP;
            else        state_s = PARITY;
         end
         STOP: begin
`ifdef UART_RX_BREAK_DET_EN
            if (done_s) state_s = brk_s ? BRK_WAIT : IDLE;
            else        state_s = STOP;
`else
            if (done_s) state_s = IDLE;
            else        state_s = STOP;
`endif
         end
`ifdef UART_RX_BREAK_DET_EN
         BRK_WAIT: begin
            if (rxs_s) state_s = IDLE;
            else       state_s = BRK_WAIT;
         end
`endif
         default: state_s = IDLE;
      endcase
   end

   // Output/strobe decode: bit-centre sample strobe, frame completion and status
   always_comb begin
      samp_s = 1'b0;
      case (state_r)
         START:              samp_s = baud_tick && (cnt_r == CNT_W'(HALF - 1));
         DATA, PARITY, STOP: samp_s = baud_tick && (cnt_r == CNT_W'(OSR - 1));
         default:            samp_s = 1'b0;
      endcase
      last_data_s = (bit_r == 4'(DATA_BITS - 1));
      done_s      = (state_r == STOP) && samp_s && (bit_r == 4'(STOP_BITS - 1));
      fe_s        = stop_err_r | ~rxs_s;
      pe_s        = parity_err(^shift_r, par_r, PARITY_MODE);
`ifdef UART_RX_BREAK_DET_EN
      first_stop_zero_s = (bit_r == 4'd0) ? ~rxs_s : stop1_zero_r;
      brk_s = (shift_r == '0) && ((PARITY_MODE == PAR_NONE) || !par_r) && first_stop_zero_s;
`else
      brk_s = 1'b0;
`endif
      load_s = done_s && (!valid_r || bus.rx_ready);
   end

   // Sample counter and bit index; both restart on every state entry
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         bit_r <= 4'd0;
      end else begin
         if ((state_s != state_r) || samp_s) cnt_r <= '0;
         else if (baud_tick)                 cnt_r <= cnt_r + CNT_W'(1);
         else                                cnt_r <= cnt_r;
         if (state_s != state_r) bit_r <= 4'd0;
         else if (samp_s)        bit_r <= bit_r + 4'd1;
         else                    bit_r <= bit_r;
      end
   end

   // Frame assembly: data shift (LSB first), parity bit and stop-bit errors
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r    <= '0;
         par_r      <= 1'b0;
         stop_err_r <= 1'b0;
      end else begin
         if ((state_r == DATA) && samp_s) shift_r <= {rxs_s, shift_r[DATA_BITS-1:1]};
         if ((state_r == PARITY) && samp_s) par_r <= rxs_s;
         if ((state_s == STOP) && (state_r != STOP))      stop_err_r <= 1'b0;
         else if ((state_r == STOP) && samp_s && !rxs_s)  stop_err_r <= 1'b1;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   // First stop bit level, needed for break detection with two stop bits
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         stop1_zero_r <= 1'b0;
      end else if ((state_r == STOP) && samp_s && (bit_r == 4'd0)) begin
         stop1_zero_r <= ~rxs_s;
      end
   end
`endif

   // Holding register: load on completion, flag overrun when still full
   always_ff @(posedge UART_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= '0;
         valid_r <= 1'b0;
         fe_r    <= 1'b0;
         pe_r    <= 1'b0;
         oe_r    <= 1'b0;
         be_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         if (load_s) begin
            data_r  <= brk_s ? '0 : shift_r;
            fe_r    <= fe_s | brk_s;
            pe_r    <= pe_s;
            oe_r    <= 1'b0;
            be_r    <= brk_s;
            valid_r <= 1'b1;
         end else if (done_s) begin
            oe_r <= 1'b1;
         end else if (valid_r && bus.rx_ready) begin
            valid_r <= 1'b0;
         end
         busy_r <= (state_s != IDLE);
      end
   end

   assign bus.rx_data  = data_r;
   assign bus.rx_valid = valid_r;
   assign bus.fe       = fe_r;
   assign bus.pe       = pe_r;
   assign bus.oe       = oe_r;
   assign bus.be       = be_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed plus randomized bench for uart_rx_os (8N/odd/1, OSR 16); words
// are predicted from the frame's bit list with plain parity arithmetic.
module tb_uart_rx_os;

   localparam int TDIV = 4;
   localparam int OSR  = 16;

   logic clk;
   logic rst_n;
   logic baud_tick;
   logic rx;
   logic busy;
   int   nvec;
   int   nerr;
   int   vhigh;
   logic [11:0] q[$];

   uart_rx_os_if #(.DATA_BITS(8)) bus ();

   uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OSR(OSR)) dut (
      .UART_clk  (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .rx        (rx),
      .busy      (busy),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (TDIV - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Consumer: count valid cycles and record each accepted word {data,fe,pe,oe,be}
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rx_valid) vhigh = vhigh + 1;
         if (bus.rx_valid && bus.rx_ready) q.push_back({bus.rx_data, bus.fe, bus.pe, bus.oe, bus.be});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic level, input int nticks);
      rx = level;
      repeat (nticks * TDIV) @(negedge clk);
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   // Reference: word plus flags from the bits actually put on the line
   function automatic logic [11:0] model(input logic [7:0] d, input logic p, input logic stop);
      logic pe;
      pe = (($countones(d) + int'(p)) % 2) == 0;
      return {d, ~stop, pe, 1'b0, 1'b0};
   endfunction

   // A zero stop bit is cut short so the re-armed start detector sees idle
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
      hold(1'b0, OSR);
      for (int i = 0; i < 8; i++) hold(d[i], OSR);
      hold(p, OSR);
      if (stop) begin
         hold(1'b1, OSR);
      end else begin
         hold(1'b0, 12);
         hold(1'b1, 4);
      end
      hold(1'b1, 2 * OSR);
   endtask

   task automatic expect_word(input string tag, input logic [11:0] exp, input int n0);
      logic [11:0] w;
      chk({tag, "_vcycles"}, 32'(vhigh - n0), 32'd1);
      chk({tag, "_count"}, 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
         w = q.pop_front();
         chk(tag, 32'(w), 32'(exp));
      end
   endtask

   initial begin
      logic [7:0]  d;
      logic        p;
      logic        st;
      logic [11:0] w;
      int          n0;
      nvec = 0;
      nerr = 0;
      vhigh = 0;
      rst_n = 1'b0;
      rx = 1'b1;
      bus.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(bus.rx_data), 32'h0);
      chk("rst_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_flags", 32'({bus.fe, bus.pe, bus.oe, bus.be}), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      hold(1'b1, OSR);

      n0 = vhigh;
      send_frame(8'hA5, 1'b1, 1'b1);
      expect_word("good_a5", model(8'hA5, 1'b1, 1'b1), n0);
      chk("good_flags", 32'(model(8'hA5, 1'b1, 1'b1) & 12'h00F), 32'h0);

      n0 = vhigh;
      send_frame(8'hA5, 1'b0, 1'b1);
      expect_word("parity_err", model(8'hA5, 1'b0, 1'b1), n0);

      n0 = vhigh;
      send_frame(8'h3C, odd_par(8'h3C), 1'b0);
      expect_word("framing_err", model(8'h3C, odd_par(8'h3C), 1'b0), n0);

      n0 = vhigh;
      hold(1'b0, 2);
      chk("glitch_busy_hi", 32'(busy), 32'h1);
      hold(1'b0, 2);
      hold(1'b1, OSR / 2);
      chk("glitch_busy_lo", 32'(busy), 32'h0);
      hold(1'b1, 2 * OSR);
      chk("glitch_novalid", 32'(vhigh - n0), 32'h0);

      for (int i = 0; i < 8; i++) begin
         d  = 8'($urandom_range(0, 255));
         p  = ($urandom_range(0, 3) != 0) ? odd_par(d) : ~odd_par(d);
         st = ($urandom_range(0, 3) != 0);
         n0 = vhigh;
         send_frame(d, p, st);
         expect_word($sformatf("rand%0d_%02h", i, d), model(d, p, st), n0);
      end

      bus.rx_ready = 1'b0;
      send_frame(8'h11, odd_par(8'h11), 1'b1);
      send_frame(8'h22, odd_par(8'h22), 1'b1);
      chk("ovr_valid", 32'(bus.rx_valid), 32'h1);
      chk("ovr_data", 32'(bus.rx_data), 32'h11);
      chk("ovr_flags", 32'({bus.fe, bus.pe, bus.oe, bus.be}), 32'h2);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      chk("ovr_accept", 32'(bus.rx_valid), 32'h0);
      chk("ovr_hold", 32'(bus.rx_data), 32'h11);
      q.delete();

      bus.rx_ready = 1'b0;
      send_frame(8'h5A, odd_par(8'h5A), 1'b1);
      hold(1'b0, 3 * OSR);
      chk("midrst_busy", 32'(busy), 32'h1);
      chk("midrst_held", 32'(bus.rx_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.rx_valid), 32'h0);
      chk("midrst_data", 32'(bus.rx_data), 32'h0);
      chk("midrst_idle", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      hold(1'b1, 2 * OSR);
      bus.rx_ready = 1'b1;
      chk("midrst_after", 32'(bus.rx_valid), 32'h0);

      n0 = vhigh;
      hold(1'b0, 22 * OSR);
`ifdef UART_RX_BREAK_DET_EN
      chk("brk_vcycles", 32'(vhigh - n0), 32'd1);
      chk("brk_count", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
         w = q.pop_front();
         chk("brk_word", 32'({w[11:4], w[3], w[0]}), 32'({8'h00, 1'b1, 1'b1}));
      end
      hold(1'b1, 2 * OSR);
`else
      chk("low_vcycles", 32'(vhigh - n0), 32'd2);
      chk("low_count", 32'(q.size()), 32'd2);
      while (q.size() > 0) begin
         w = q.pop_front();
         chk("low_word", 32'({w[11:4], w[3], w[0]}), 32'({8'h00, 1'b1, 1'b0}));
      end
      hold(1'b1, 24 * OSR);
      q.delete();
`endif
      n0 = vhigh;
      send_frame(8'h55, odd_par(8'h55), 1'b1);
      expect_word("post_low_55", model(8'h55, odd_par(8'h55), 1'b1), n0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, the successor to the fixed 8-bit, 11-bit-frame receiver. It synchronises the asynchronous `rx` line and samples each bit at its centre from an OSR× baud tick. Data width, parity mode and stop-bit count are configurable. Each received word is delivered through a valid/ready holding register, with framing, parity, overrun and break status attached. It sits between the pad-side `rx` input and the bus/FIFO consumer.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY_MODE`, default 1: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `OSR`, default 16: baud ticks per bit; even, ≥4.
- `UART_clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `baud_tick`  in  1  one-cycle pulse at OSR × baud rate.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  DATA_BITS  received word, LSB first on the line.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `fe`, `pe`, `oe`, `be`  out  1 each  status for the held word: framing, parity, overrun, break.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions below use the synchronised signal `rxs`.
- Sample counter: $clog2(OSR) bits. It advances only on `baud_tick` and clears on every state entry.
- **IDLE**: `rxs == 0` → START.
- **START**: sample after OSR/2 ticks.
  - If `rxs == 1`, this is a false start: return to IDLE with no output and no flags.
  - Otherwise go to DATA.
- **DATA**: sample every OSR ticks and shift right into the shift register (LSB first). After DATA_BITS samples go to PARITY, or to STOP when `PARITY_MODE == 0`.
- **PARITY**: sample one bit.
  - Odd mode: `pe = (^data ^ par) == 0`.
  - Even mode: `pe = (^data ^ par) == 1`.
  - With `PARITY_MODE == 0`, `pe` is always 0.
- **STOP**: sample STOP_BITS bits. `fe = 1` if any sampled stop bit is 0.
- Frame completion happens on the last stop sample:
  - The word and flags load into the holding register.
  - `rx_valid` goes to 1.
  - Next state is BRK_WAIT if a break was detected, otherwise IDLE.
- **Overrun**: a frame completes while `rx_valid == 1` and the held word is not accepted in the same cycle.
  - The new frame is discarded.
  - The held `rx_data` is kept and its `oe` is set to 1.
- **Simultaneous accept and completion**: the new word loads and `rx_valid` stays 1. No overrun.
- **Accept** (`rx_valid && rx_ready`, no new frame in that cycle): `rx_valid` goes to 0. Data and flags hold their last values.
- **Reset mid-frame**: return to IDLE immediately. The partial frame is discarded and the holding register clears.

## Timing
- Reset values: `rx_data` = 0; `rx_valid`, `fe`, `pe`, `oe`, `be`, `busy` = 0.
- Input latency: 2 `UART_clk` cycles through the synchroniser.
- `rx_valid` asserts one `UART_clk` cycle after the `baud_tick` on which the last stop bit was sampled.
- Bit n (start = 0) is sampled at OSR/2 + n·OSR ticks after start detection.
- Flags are registered together with `rx_data` and are valid only while `rx_valid == 1`.

## Configuration
- Macro `UART_RX_BREAK_DET_EN`.
- **Defined:**
  - A break is all data bits 0, the parity bit 0 (if parity is present) and the first stop bit 0.
  - On a break: `be = 1`, `fe = 1`, `rx_data = 0`, and the FSM enters BRK_WAIT.
  - BRK_WAIT stays until `rxs == 1`, then goes to IDLE, so one break yields exactly one word.
- **Undefined:**
  - `be` is tied to 0 and the BRK_WAIT state does not exist.
  - A held-low line yields repeated all-zero words with `fe = 1`, one per frame time.

## Structure
- Package `uart_pkg` holds:
  - parity constants `PAR_NONE = 0`, `PAR_ODD = 1`, `PAR_EVEN = 2`;
  - the state encoding: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- One sub-module, `uart_sync2`: the reset-to-1 two-flop synchroniser, reused by future blocks.

## Test plan
All scenarios use OSR = 16, 8 data bits, odd parity, 1 stop bit, `rx_ready = 1` unless stated.
- **Good frame**: send 0xA5 with parity bit 1 → `rx_data = 0xA5`, `rx_valid` asserts for 1 cycle, all flags 0.
- **Parity error**: send 0xA5 with parity bit 0 → `rx_data = 0xA5`, `pe = 1`, `fe = 0`.
- **Framing error**: send 0x3C with a correct parity bit and stop bit 0 → `fe = 1`, `rx_data = 0x3C`, `be = 0`.
- **Glitch**: drive `rx` low for 4 ticks, then high → no `rx_valid`; `busy` drops within OSR/2 ticks.
- **Overrun**: hold `rx_ready = 0` and send 0x11 then 0x22 → `rx_data = 0x11`, `oe = 1`. Then raise `rx_ready` → `rx_valid` drops after 1 cycle.
- **Break** (macro defined): hold `rx` low for 2 frame times, then high, then send 0x55.
  - First word: `rx_data = 0x00`, `be = 1`, `fe = 1`, and exactly one `rx_valid` during the low period.
  - Second word: `rx_data = 0x55`, flags 0.
